// File: rtl/sram_responder.sv
// Device-side model of a 16-bit async SRAM: byte-lane writes, reads answered after READ_LATENCY stable clocks.
// Optional protocol checker built only when SRAM_RESPONDER_PROTO_CHECK_EN is defined; otherwise proto_err is tied low.
module sram_responder #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 18,
  parameter int MEM_AW       = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_LB_N,
  input  logic              SRAM_WE_N,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_OE_N,
  output logic [15:0]       wr_count,
  output logic              rd_valid,
  output logic              proto_err
);

  localparam int HB = DATA_W / 2;
  localparam logic [3:0] LAT = READ_LATENCY[3:0];

  typedef enum logic [1:0] {IDLE, WAIT, DRIVE} state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic [ADDR_W-1:0]   held_addr, held_addr_nxt;
  logic                load_rdata;
  logic [DATA_W-1:0]   rdata;
  logic [DATA_W-1:0]   mem [2**MEM_AW];
  logic [MEM_AW-1:0]   word_addr;
  logic                wr_cyc, rd_cyc, drive_en;

  assign wr_cyc    = !SRAM_CE_N && !SRAM_WE_N;
  assign rd_cyc    = !SRAM_CE_N &&  SRAM_WE_N && !SRAM_OE_N;
  assign word_addr = SRAM_ADDR[MEM_AW-1:0];

  // The array sits outside reset so a write on the reset edge still lands.
  always_ff @(posedge clk) begin
    if (wr_cyc) begin
      if (!SRAM_UB_N) mem[word_addr][DATA_W-1:HB] <= SRAM_DQ[DATA_W-1:HB];
      if (!SRAM_LB_N) mem[word_addr][HB-1:0]      <= SRAM_DQ[HB-1:0];
    end
    if (load_rdata) rdata <= mem[word_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      held_addr <= '0;
      wr_count  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      held_addr <= held_addr_nxt;
      if (wr_cyc) wr_count <= wr_count + 16'd1;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    held_addr_nxt = held_addr;
    load_rdata    = 1'b0;
    if (!rd_cyc) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (state == IDLE || SRAM_ADDR != held_addr) begin
      // A new request (or a changed address) restarts the latency count.
      held_addr_nxt = SRAM_ADDR;
      cnt_nxt       = 4'd1;
      if (LAT == 4'd1) begin
        state_nxt  = DRIVE;
        load_rdata = 1'b1;
      end else begin
        state_nxt = WAIT;
      end
    end else if (state == WAIT) begin
      cnt_nxt = cnt + 4'd1;
      if (cnt + 4'd1 == LAT) begin
        state_nxt  = DRIVE;
        load_rdata = 1'b1;
      end
    end
  end

  assign rd_valid = (state == DRIVE);
  // Drive is also gated by the live strobes so a write or deselect never fights the bus.
  assign drive_en = rd_valid && rd_cyc;
  assign SRAM_DQ[DATA_W-1:HB] = (drive_en && !SRAM_UB_N) ? rdata[DATA_W-1:HB] : 'z;
  assign SRAM_DQ[HB-1:0]      = (drive_en && !SRAM_LB_N) ? rdata[HB-1:0]      : 'z;

`ifdef SRAM_RESPONDER_PROTO_CHECK_EN
  logic contention, no_lane, alias_acc;
  assign contention = !SRAM_CE_N && !SRAM_WE_N && !SRAM_OE_N;
  assign no_lane    = wr_cyc && SRAM_UB_N && SRAM_LB_N;
  assign alias_acc  = (wr_cyc || rd_cyc) && (SRAM_ADDR[ADDR_W-1:MEM_AW] != '0);

  always_ff @(posedge clk) begin
    if (rst)                                    proto_err <= 1'b0;
    else if (contention || no_lane || alias_acc) proto_err <= 1'b1;
  end
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Table-driven bench with a read scoreboard for sram_responder (default parameters).
module tb_sram_responder;

`ifdef SRAM_RESPONDER_PROTO_CHECK_EN
  localparam logic PROTO = 1'b1;
`else
  localparam logic PROTO = 1'b0;
`endif
  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] addr;
  logic        ub_n, lb_n, we_n, ce_n, oe_n;
  logic [15:0] dq_drv;
  logic        dq_en;
  wire  [15:0] sram_dq;
  logic [15:0] wr_count;
  logic        rd_valid, proto_err;

  assign sram_dq = dq_en ? dq_drv : 'z;

  sram_responder dut (
    .clk(clk), .rst(rst), .SRAM_DQ(sram_dq), .SRAM_ADDR(addr),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .wr_count(wr_count), .rd_valid(rd_valid), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [17:0] addr;
    logic [15:0] data;
    logic        ub_n;
    logic        lb_n;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        ub_n;
    logic        lb_n;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          passed = 0;
  logic [15:0] cnt_model = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // A 2-state simulator resolves an undriven lane to 0, a 4-state one to z.
  task automatic check_z(input string name, input logic [7:0] v);
    total++;
    if (v === 8'hzz || v === 8'h00) passed++;
    else $display("FAIL %s: lane got %0h expected z", name, v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; ub_n = 1'b0; lb_n = 1'b0; dq_en = 1'b0;
  endtask

  task automatic do_write(input logic [17:0] a, input logic [15:0] d, input logic u, input logic l);
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; addr = a; ub_n = u; lb_n = l;
    dq_drv = d; dq_en = 1'b1;
    step();
    cnt_model++;
    idle();
    step();
  endtask

  task automatic compare_read(input string name);
    exp_t e;
    e = sb.pop_front();
    if (!e.ub_n) check({name, "_hi"}, {24'd0, sram_dq[15:8]}, {24'd0, e.data[15:8]});
    else         check_z({name, "_hi_z"}, sram_dq[15:8]);
    if (!e.lb_n) check({name, "_lo"}, {24'd0, sram_dq[7:0]}, {24'd0, e.data[7:0]});
    else         check_z({name, "_lo_z"}, sram_dq[7:0]);
  endtask

  // Waits (bounded) for rd_valid, returning the number of edges taken; 0 on timeout.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (rd_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic do_read(input string name, input logic [17:0] a, input logic [15:0] exp,
                         input logic u, input logic l);
    int lat;
    exp_t e;
    e.data = exp; e.ub_n = u; e.lb_n = l;
    sb.push_back(e);
    ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; addr = a; ub_n = u; lb_n = l; dq_en = 1'b0;
    wait_valid(lat);
    check({name, "_latency"}, lat, RL);
    if (lat != 0) compare_read(name);
    else void'(sb.pop_front());
    idle();
    step();
  endtask

  vec_t vecs[15];

  initial begin
    int lat;
    logic seen_beef;
    int n;

    vecs[0]  = '{1'b1, 18'h005, 16'hBEEF, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 18'h005, 16'hBEEF, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 18'h007, 16'h1234, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 18'h007, 16'hAB00, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 18'h007, 16'hAB34, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 18'h007, 16'hAB34, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 18'h00A, 16'h1111, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 18'h00A, 16'h2222, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 18'h00A, 16'hFFFF, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 18'h00A, 16'h2211, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 18'h400, 16'h5555, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 18'h000, 16'h5555, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 18'h400, 16'h5555, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 18'h005, 16'hBEEF, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 18'h007, 16'hAB34, 1'b0, 1'b1};

    rst = 1'b1; addr = '0; dq_drv = '0;
    idle();
    step(); step();
    rst = 1'b0;
    check("reset_wr_count", wr_count, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_proto_err", proto_err, 0);
    check_z("reset_dq_hi", sram_dq[15:8]);
    check_z("reset_dq_lo", sram_dq[7:0]);

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].ub_n, vecs[i].lb_n);
      else do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].ub_n, vecs[i].lb_n);
    end
    check("table_wr_count", wr_count, {16'd0, cnt_model});
    check("table_proto_err", proto_err, {31'd0, PROTO});

    // Address change one clock into a read restarts the latency.
    ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; addr = 18'h005;
    step();
    check("addr_chg_not_valid", rd_valid, 0);
    addr = 18'h007;
    sb.push_back('{16'hAB34, 1'b0, 1'b0});
    seen_beef = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (sram_dq === 16'hBEEF) seen_beef = 1'b1;
      step();
      if (sram_dq === 16'hBEEF) seen_beef = 1'b1;
      if (rd_valid) begin
        lat = i;
        break;
      end
    end
    check("addr_chg_latency", lat, RL);
    check("addr_chg_no_beef", seen_beef, 0);
    if (lat != 0) compare_read("addr_chg");
    else void'(sb.pop_front());
    idle();
    step();

    // Multi-cycle write pulse: last value wins, each edge counts.
    ce_n = 1'b0; we_n = 1'b0; addr = 18'h020; dq_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      dq_drv = 16'(i);
      step();
      cnt_model++;
    end
    idle();
    step();
    check("multi_wr_count", wr_count, {16'd0, cnt_model});
    do_read("multi_wr", 18'h020, 16'h0003, 1'b0, 1'b0);

    // Reset mid-read, with a write presented on the reset edge.
    ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; addr = 18'h005;
    wait_valid(lat);
    check("pre_rst_valid", rd_valid, 1);
    rst = 1'b1; we_n = 1'b0; oe_n = 1'b1; addr = 18'h040; dq_drv = 16'h7777; dq_en = 1'b1;
    step();
    rst = 1'b0;
    cnt_model = 16'd0;
    idle();
    check("rst_rd_valid", rd_valid, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_proto_err", proto_err, 0);
    step();
    do_read("rst_edge_write", 18'h040, 16'h7777, 1'b0, 1'b0);
    do_read("retained", 18'h005, 16'hBEEF, 1'b0, 1'b0);

    // Contention: write wins, DUT stays off the bus.
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b0; addr = 18'h030; dq_drv = 16'hC0DE; dq_en = 1'b1;
    step();
    cnt_model++;
    check("contend_rd_valid", rd_valid, 0);
    idle();
    step();
    check("contend_proto_err", proto_err, {31'd0, PROTO});
    do_read("contend", 18'h030, 16'hC0DE, 1'b0, 1'b0);

    // Deselected chip ignores write and read strobes.
    ce_n = 1'b1; we_n = 1'b0; addr = 18'h030; dq_drv = 16'h0000; dq_en = 1'b1;
    step();
    dq_en = 1'b0; we_n = 1'b1; oe_n = 1'b0;
    step(); step(); step();
    check("ce_off_rd_valid", rd_valid, 0);
    check("ce_off_wr_count", wr_count, {16'd0, cnt_model});
    idle();
    step();
    do_read("ce_off", 18'h030, 16'hC0DE, 1'b0, 1'b0);

    // wr_count wrap.
    n = 16'hFFFF - cnt_model;
    ce_n = 1'b0; we_n = 1'b0; addr = 18'h050; dq_drv = 16'h0050; dq_en = 1'b1;
    repeat (n) step();
    check("wrap_ffff", wr_count, 32'h0000FFFF);
    step();
    idle();
    check("wrap_zero", wr_count, 0);
    step();

    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Synthesizable device-side model of the external 16-bit asynchronous SRAM.
- Answers the SRAM pin interface driven by the MEM-stage SRAM controller: SRAM_DQ, SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N.
- Lets the pipeline run on-chip (simulation or FPGA without the board SRAM), with programmable read access latency and byte-lane writes.

Parameters:
- DATA_W, 16, SRAM data bus width (equals SRAM_DATA_LEN).
- ADDR_W, 18, SRAM address bus width (equals SRAM_ADDR_LEN).
- MEM_AW, 10, implemented word-address bits. Depth = 2^MEM_AW words; upper address bits are ignored, so addresses alias.
- READ_LATENCY, 2, clocks a read must be held stable before SRAM_DQ is driven. Legal range 1..15.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- SRAM_DQ, inout, DATA_W, bidirectional data bus. Driven only during a valid read; Z otherwise.
- SRAM_ADDR, input, ADDR_W, word address.
- SRAM_UB_N, input, 1, upper byte lane enable [15:8], active low.
- SRAM_LB_N, input, 1, lower byte lane enable [7:0], active low.
- SRAM_WE_N, input, 1, write enable, active low.
- SRAM_CE_N, input, 1, chip enable, active low.
- SRAM_OE_N, input, 1, output enable, active low.
- wr_count, output, 16, number of write cycles accepted (debug).
- rd_valid, output, 1, high while SRAM_DQ is being driven with read data.
- proto_err, output, 1, sticky protocol-error flag (see Optional Feature).

Behaviour:
- Reset: wr_count=0, rd_valid=0, latency counter=0, proto_err=0, SRAM_DQ=Z. Memory array contents are NOT cleared by reset.
- Decode (sampled each rising clk edge):
  - wr_cyc = !CE_N & !WE_N.
  - rd_cyc = !CE_N & WE_N & !OE_N.
- Write:
  - On each edge with wr_cyc, mem[ADDR[MEM_AW-1:0]] is updated per lane: [15:8] from DQ if !UB_N, [7:0] from DQ if !LB_N.
  - Both lanes disabled: no memory change, but wr_count still increments.
  - wr_count increments by 1 per wr_cyc edge and wraps 0xFFFF -> 0.
  - A multi-cycle write pulse writes each cycle; the last value wins.
  - Write has priority: wr_cyc overrides OE_N, and DQ stays Z whenever WE_N=0.
- Read latency state machine, states IDLE / WAIT / DRIVE:
  - IDLE: rd_cyc -> WAIT, cnt=1, latch held_addr=ADDR.
  - WAIT: rd_cyc and ADDR==held_addr -> cnt++. When cnt reaches READ_LATENCY, register rdata=mem[held_addr] and go to DRIVE.
  - WAIT: rd_cyc with a different ADDR -> stay in WAIT, cnt=1, held_addr=ADDR.
  - DRIVE: rd_valid=1. DQ[15:8]=rdata[15:8] if !UB_N else Z; DQ[7:0]=rdata[7:0] if !LB_N else Z. Lane gating is combinational on UB_N/LB_N.
  - DRIVE: ADDR change while rd_cyc -> WAIT, cnt=1, DQ=Z from the next edge.
  - Any state: !rd_cyc -> IDLE, rd_valid=0, DQ=Z from the next edge.
  - READ_LATENCY=1: IDLE goes directly to DRIVE on the first rd_cyc edge, so data appears 1 clock after the request.
- Read-after-write to the same address returns the newly written data. The write completes on the edge before the read sequence starts.
- Reset asserted mid-read: FSM returns to IDLE and DQ goes to Z on that edge. A write on the reset edge is still committed to memory, because the array is not under reset.
- CE_N=1: all inputs ignored, DQ=Z, FSM held in IDLE.

Optional Feature:
- Macro: SRAM_RESPONDER_PROTO_CHECK_EN.
- Defined: proto_err is set (sticky until rst) on any edge with:
  - !CE_N & !WE_N & !OE_N (bus contention), or
  - !CE_N & !WE_N & UB_N & LB_N (write with no lane), or
  - ADDR[ADDR_W-1:MEM_AW] != 0 during wr_cyc or rd_cyc (aliasing access).
  - Memory behaviour is unchanged.
- Not defined: proto_err is tied 0 and no check logic is built.

Test Plan:
- Reset, then full write: CE_N=0, WE_N=0, UB_N=LB_N=0, ADDR=0x00005, DQ=0xBEEF for 1 clk. Then read with OE_N=0, WE_N=1, READ_LATENCY=2 -> DQ=Z for 2 clks, then DQ=0xBEEF with rd_valid=1; wr_count=1.
- Byte lanes: write 0x1234 to ADDR 7, then write 0xAB00 with LB_N=1 -> read returns 0xAB34. Read with UB_N=1 -> DQ[15:8]=Z, DQ[7:0]=0x34.
- Address change mid-read: read ADDR 5, change ADDR to 7 after 1 clk -> latency restarts; 0x1234 (or 0xAB34 after the byte-lane test) appears 2 clks after the change, and 0xBEEF is never driven.
- Aliasing: write 0x5555 at ADDR 0x00400 with MEM_AW=10 -> read ADDR 0 returns 0x5555. With the macro defined, proto_err=1.
- Contention and reset: WE_N=0, OE_N=0, CE_N=0 -> DQ stays Z and memory is written; proto_err=1 when the macro is defined. Then pulse rst -> proto_err=0, wr_count=0, and memory at ADDR 5 still reads 0xBEEF.
- wr_count wrap: 65536 single-cycle writes -> wr_count returns to 0.
